// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin shared-register arbiter:
// FSM state encodings, a constant clog2 helper and the lock-run limit.
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

    // Maximum number of consecutive lock regrants before rotation is forced.
    localparam int MAX_LOCK = 4;

    // Constant-evaluable ceiling log2, used for index widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request bit found when
// searching from ptr upward, wrapping past NUM_REQ-1 back to 0.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               any,
    output logic [PTR_W-1:0]   idx
);

    // Scan candidates ptr, ptr+1, ... (mod NUM_REQ); first hit wins.
    always_comb begin
        int c;
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path can leave it holding a stale value (no latch inferred).
        c   = 0;
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!any && req[PTR_W'(c)]) begin
                any = 1'b1;
                idx = PTR_W'(c);
            end
        end
    end

endmodule

// File: rtl/rr_ff_arbiter.sv
// Round-robin arbiter owning one DATA_W-bit shared register among NUM_REQ
// requesters. FSM IDLE -> LOAD -> HOLD (HOLD_CYCLES cycles) -> IDLE; all
// outputs are registered. Optional feature macro ARB_LOCK_EN adds a lock
// input that lets the current owner be regranted directly, at most MAX_LOCK
// times in a row.
module rr_ff_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          lock,
`endif
    output logic [NUM_REQ-1:0]          grant,
    output logic [DATA_W-1:0]           q,
    output logic                        q_upd,
    output logic [clog2(NUM_REQ)-1:0]   owner,
    output logic                        busy
);

    localparam int PTR_W = clog2(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic                q_upd_q, q_upd_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [PTR_W-1:0]    ptr_q,   ptr_d;
    logic                busy_q,  busy_d;
    logic [3:0]          cnt_q,   cnt_d;

`ifdef ARB_LOCK_EN
    // lock_act_q marks an ongoing run of regrants; lock_cnt_q then counts
    // regrants already made minus one, so values 0..3 cover MAX_LOCK regrants.
    logic                lock_act_q, lock_act_d;
    logic [1:0]          lock_cnt_q, lock_cnt_d;
    logic                lock_ok;
`endif

    logic                pick_any;
    logic [PTR_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   owner_slice;
    logic [PTR_W-1:0]    ptr_next;
    logic                end_own;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Select the owner's data slice with constant part-selects.
    always_comb begin
        owner_slice = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == PTR_W'(i)) owner_slice = wdata[i*DATA_W +: DATA_W];
        end
    end

    // Rotation pointer successor of the current owner, wrapping to 0.
    always_comb begin
        ptr_next = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d = state_q;
        grant_d = '0;
        data_d  = data_q;
        q_upd_d = 1'b0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        end_own = 1'b0;
`ifdef ARB_LOCK_EN
        lock_act_d = lock_act_q;
        lock_cnt_d = lock_cnt_q;
        lock_ok    = !(lock_act_q && (lock_cnt_q == 2'(MAX_LOCK - 1)));
`endif

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = NUM_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    state_d = LOAD;
`ifdef ARB_LOCK_EN
                    lock_act_d = 1'b0;
                    lock_cnt_d = '0;
`endif
                end
            end
            LOAD: begin
                // The load completes even if req dropped during this cycle.
                data_d  = owner_slice;
                q_upd_d = 1'b1;
                ptr_d   = ptr_next;
                if (HOLD_CYCLES == 0) begin
                    end_own = 1'b1;
                end else begin
                    cnt_d   = 4'(HOLD_CYCLES - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) end_own = 1'b1;
                else             cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        if (end_own) begin
            state_d = IDLE;
`ifdef ARB_LOCK_EN
            if (lock[owner_q] && req[owner_q] && lock_ok) begin
                state_d = LOAD;
                grant_d = NUM_REQ'(1) << owner_q;
                if (lock_act_q) begin
                    lock_cnt_d = lock_cnt_q + 2'd1;
                end else begin
                    lock_act_d = 1'b1;
                    lock_cnt_d = '0;
                end
            end else begin
                lock_act_d = 1'b0;
                lock_cnt_d = '0;
            end
`endif
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset overriding all.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            // The shared register is a plain flop bank, so it is cleared too.
            state_q <= IDLE;
            grant_q <= '0;
            data_q  <= '0;
            q_upd_q <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef ARB_LOCK_EN
            lock_act_q <= 1'b0;
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            q_upd_q <= q_upd_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
`ifdef ARB_LOCK_EN
            lock_act_q <= lock_act_d;
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    assign grant = grant_q;
    assign q     = data_q;
    assign q_upd = q_upd_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule
